// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-port signals shared by the arbiter and its clients.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ack;
    logic              ic_err;
    logic [DATA_W-1:0] ic_rdata;

    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_rd_wr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ack;
    logic              dc_err;
    logic [DATA_W-1:0] dc_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_rd_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  ic_req, ic_addr,
        output ic_ack, ic_err, ic_rdata,
        input  dc_req, dc_addr, dc_rd_wr, dc_wdata,
        output dc_ack, dc_err, dc_rdata,
        output mem_addr, mem_en, mem_rd_wr, mem_wdata,
        input  mem_data_valid, mem_rdata
    );

    // Requester and memory side
    modport master (
        output ic_req, ic_addr,
        input  ic_ack, ic_err, ic_rdata,
        output dc_req, dc_addr, dc_rd_wr, dc_wdata,
        input  dc_ack, dc_err, dc_rdata,
        input  mem_addr, mem_en, mem_rd_wr, mem_wdata,
        output mem_data_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared icache/dcache memory port, with access timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned WCNT_W = 8;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                ic_ack_q, ic_ack_d;
    logic                ic_err_q, ic_err_d;
    logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic                dc_ack_q, dc_ack_d;
    logic                dc_err_q, dc_err_d;
    logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rd_wr_q, mem_rd_wr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                pick_dc_c;

    // On a tie the requester that did not win last time gets the port
    assign pick_dc_c = bus.dc_req && (!bus.ic_req || !last_grant_q);

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wcnt_d       = wcnt_q;
        ic_ack_d     = 1'b0;
        ic_err_d     = ic_err_q;
        ic_rdata_d   = ic_rdata_q;
        dc_ack_d     = 1'b0;
        dc_err_d     = dc_err_q;
        dc_rdata_d   = dc_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_en_d     = 1'b0;
        mem_rd_wr_d  = mem_rd_wr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    last_grant_d = pick_dc_c;
                    wcnt_d       = '0;
                    mem_en_d     = 1'b1;
                    state_d      = BUSY;
                    if (pick_dc_c) begin
                        mem_addr_d  = bus.dc_addr;
                        mem_rd_wr_d = bus.dc_rd_wr;
                        mem_wdata_d = bus.dc_wdata;
                    end else begin
                        mem_addr_d  = bus.ic_addr;
                        mem_rd_wr_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_data_valid || (wcnt_q == WCNT_LAST)) begin
                    // Valid wins over a timeout landing in the same cycle
                    state_d = RESP;
                    if (last_grant_q) begin
                        dc_ack_d = 1'b1;
                        dc_err_d = !bus.mem_data_valid;
                        if (bus.mem_data_valid && mem_rd_wr_q) begin
                            dc_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        ic_ack_d = 1'b1;
                        ic_err_d = !bus.mem_data_valid;
                        if (bus.mem_data_valid) begin
                            ic_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    wcnt_d   = wcnt_q + WCNT_W'(1);
                    mem_en_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wcnt_q       <= '0;
            ic_ack_q     <= 1'b0;
            ic_err_q     <= 1'b0;
            ic_rdata_q   <= '0;
            dc_ack_q     <= 1'b0;
            dc_err_q     <= 1'b0;
            dc_rdata_q   <= '0;
            mem_addr_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_rd_wr_q  <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wcnt_q       <= wcnt_d;
            ic_ack_q     <= ic_ack_d;
            ic_err_q     <= ic_err_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_ack_q     <= dc_ack_d;
            dc_err_q     <= dc_err_d;
            dc_rdata_q   <= dc_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_en_q     <= mem_en_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.ic_ack    = ic_ack_q;
    assign bus.ic_err    = ic_err_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_ack    = dc_ack_q;
    assign bus.dc_err    = dc_err_q;
    assign bus.dc_rdata  = dc_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rd_wr = mem_rd_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus tie, timeout and reset sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ic_req;
        logic [31:0] ic_addr;
        logic        dc_req;
        logic [31:0] dc_addr;
        logic        dc_rd_wr;
        logic [31:0] dc_wdata;
        logic        mdv;
        logic [31:0] mrdata;
        logic        e_ic_ack;
        logic        e_ic_err;
        logic [31:0] e_ic_rdata;
        logic        e_dc_ack;
        logic        e_dc_err;
        logic [31:0] e_dc_rdata;
        logic        e_mem_en;
        logic        e_mem_rd_wr;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        logic icr, logic [31:0] ica, logic dcr, logic [31:0] dca, logic dcrw, logic [31:0] dcwd,
        logic mdv, logic [31:0] mrd,
        logic eia, logic eie, logic [31:0] eird, logic eda, logic ede, logic [31:0] edrd,
        logic een, logic erw, logic [31:0] eaddr, logic [31:0] ewd);
        vec_t v;
        v.ic_req = icr;  v.ic_addr = ica;  v.dc_req = dcr;  v.dc_addr = dca;
        v.dc_rd_wr = dcrw;  v.dc_wdata = dcwd;  v.mdv = mdv;  v.mrdata = mrd;
        v.e_ic_ack = eia;  v.e_ic_err = eie;  v.e_ic_rdata = eird;
        v.e_dc_ack = eda;  v.e_dc_err = ede;  v.e_dc_rdata = edrd;
        v.e_mem_en = een;  v.e_mem_rd_wr = erw;  v.e_mem_addr = eaddr;  v.e_mem_wdata = ewd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ic_req = 1'b0;  bus.ic_addr = '0;
        bus.dc_req = 1'b0;  bus.dc_addr = '0;  bus.dc_rd_wr = 1'b0;  bus.dc_wdata = '0;
        bus.mem_data_valid = 1'b0;  bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Table: inputs applied in one cycle, outputs expected in the next
        vecs[0]  = mk(1, 32'h40, 0, 32'h0, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        1, 1, 32'h40,  32'h0);
        vecs[1]  = mk(1, 32'h40, 0, 32'h0, 1, 32'h0,        1, 32'h40,       1, 0, 32'h40,   0, 0, 32'h0,        0, 1, 32'h40,  32'h0);
        vecs[2]  = mk(0, 32'h40, 0, 32'h0, 1, 32'h0,        1, 32'h1234,     0, 0, 32'h40,   0, 0, 32'h0,        0, 1, 32'h40,  32'h0);
        vecs[3]  = mk(0, 32'h0,  1, 32'h80, 0, 32'hDEADBEEF, 0, 32'h0,       0, 0, 32'h40,   0, 0, 32'h0,        1, 0, 32'h80,  32'hDEADBEEF);
        vecs[4]  = mk(0, 32'h0,  1, 32'h80, 0, 32'hDEADBEEF, 1, 32'h5555,    0, 0, 32'h40,   1, 0, 32'h0,        0, 0, 32'h80,  32'hDEADBEEF);
        vecs[5]  = mk(0, 32'h0,  0, 32'h80, 0, 32'hDEADBEEF, 0, 32'h0,       0, 0, 32'h40,   0, 0, 32'h0,        0, 0, 32'h80,  32'hDEADBEEF);
        vecs[6]  = mk(0, 32'h0,  1, 32'h84, 1, 32'h11111111, 0, 32'h0,       0, 0, 32'h40,   0, 0, 32'h0,        1, 1, 32'h84,  32'h11111111);
        vecs[7]  = mk(0, 32'h0,  1, 32'h99, 0, 32'h22222222, 0, 32'h0,       0, 0, 32'h40,   0, 0, 32'h0,        1, 1, 32'h84,  32'h11111111);
        vecs[8]  = mk(0, 32'h0,  1, 32'h99, 0, 32'h22222222, 1, 32'hCAFEF00D, 0, 0, 32'h40,  1, 0, 32'hCAFEF00D, 0, 1, 32'h84,  32'h11111111);
        vecs[9]  = mk(0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 32'h0,       0, 0, 32'h40,   0, 0, 32'hCAFEF00D, 0, 1, 32'h84,  32'h11111111);
        vecs[10] = mk(1, 32'h100, 0, 32'h0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h40,   0, 0, 32'hCAFEF00D, 1, 1, 32'h100, 32'h11111111);
        vecs[11] = mk(1, 32'h200, 0, 32'h0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h40,   0, 0, 32'hCAFEF00D, 1, 1, 32'h100, 32'h11111111);
        vecs[12] = mk(1, 32'h200, 0, 32'h0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h40,   0, 0, 32'hCAFEF00D, 1, 1, 32'h100, 32'h11111111);
        vecs[13] = mk(1, 32'h200, 0, 32'h0, 0, 32'h0,        0, 32'h0,       0, 0, 32'h40,   0, 0, 32'hCAFEF00D, 1, 1, 32'h100, 32'h11111111);
        vecs[14] = mk(1, 32'h200, 0, 32'h0, 0, 32'h0,        1, 32'hABCD,    1, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 0, 1, 32'h100, 32'h11111111);
        vecs[15] = mk(0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 32'h0,       0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 0, 1, 32'h100, 32'h11111111);
        vecs[16] = mk(0, 32'h0,  1, 32'h300, 1, 32'h33333333, 0, 32'h0,      0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 1, 1, 32'h300, 32'h33333333);
        vecs[17] = mk(0, 32'h0,  1, 32'h300, 1, 32'h33333333, 0, 32'h0,      0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 1, 1, 32'h300, 32'h33333333);
        vecs[18] = mk(0, 32'h0,  1, 32'h300, 1, 32'h33333333, 0, 32'h0,      0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 1, 1, 32'h300, 32'h33333333);
        vecs[19] = mk(0, 32'h0,  1, 32'h300, 1, 32'h33333333, 0, 32'h0,      0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 1, 1, 32'h300, 32'h33333333);
        vecs[20] = mk(0, 32'h0,  1, 32'h300, 1, 32'h33333333, 0, 32'h9999,   0, 0, 32'hABCD, 1, 1, 32'hCAFEF00D, 0, 1, 32'h300, 32'h33333333);
        vecs[21] = mk(0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 32'h0,       0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 0, 1, 32'h300, 32'h33333333);
        vecs[22] = mk(1, 32'h44, 0, 32'h0,  0, 32'h0,        0, 32'h0,       0, 0, 32'hABCD, 0, 0, 32'hCAFEF00D, 1, 1, 32'h44,  32'h33333333);
        vecs[23] = mk(1, 32'h44, 0, 32'h0,  0, 32'h0,        1, 32'h77,      1, 0, 32'h77,   0, 0, 32'hCAFEF00D, 0, 1, 32'h44,  32'h33333333);
        vecs[24] = mk(0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 32'h0,       0, 0, 32'h77,   0, 0, 32'hCAFEF00D, 0, 1, 32'h44,  32'h33333333);

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("reset ic_ack",    32'(bus.ic_ack),    32'h0);
        check("reset dc_ack",    32'(bus.dc_ack),    32'h0);
        check("reset ic_err",    32'(bus.ic_err),    32'h0);
        check("reset dc_err",    32'(bus.dc_err),    32'h0);
        check("reset mem_en",    32'(bus.mem_en),    32'h0);
        check("reset mem_rd_wr", 32'(bus.mem_rd_wr), 32'h0);
        check("reset mem_addr",  bus.mem_addr,       32'h0);
        check("reset mem_wdata", bus.mem_wdata,      32'h0);
        check("reset ic_rdata",  bus.ic_rdata,       32'h0);
        check("reset dc_rdata",  bus.dc_rdata,       32'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            bus.ic_req = vecs[i].ic_req;    bus.ic_addr = vecs[i].ic_addr;
            bus.dc_req = vecs[i].dc_req;    bus.dc_addr = vecs[i].dc_addr;
            bus.dc_rd_wr = vecs[i].dc_rd_wr; bus.dc_wdata = vecs[i].dc_wdata;
            bus.mem_data_valid = vecs[i].mdv; bus.mem_rdata = vecs[i].mrdata;
            tick();
            check($sformatf("vec%0d ic_ack", i),    32'(bus.ic_ack),    32'(vecs[i].e_ic_ack));
            check($sformatf("vec%0d ic_rdata", i),  bus.ic_rdata,       vecs[i].e_ic_rdata);
            check($sformatf("vec%0d dc_ack", i),    32'(bus.dc_ack),    32'(vecs[i].e_dc_ack));
            check($sformatf("vec%0d dc_rdata", i),  bus.dc_rdata,       vecs[i].e_dc_rdata);
            check($sformatf("vec%0d mem_en", i),    32'(bus.mem_en),    32'(vecs[i].e_mem_en));
            check($sformatf("vec%0d mem_rd_wr", i), 32'(bus.mem_rd_wr), 32'(vecs[i].e_mem_rd_wr));
            check($sformatf("vec%0d mem_addr", i),  bus.mem_addr,       vecs[i].e_mem_addr);
            check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata,      vecs[i].e_mem_wdata);
            if (vecs[i].e_ic_ack) check($sformatf("vec%0d ic_err", i), 32'(bus.ic_err), 32'(vecs[i].e_ic_err));
            if (vecs[i].e_dc_ack) check($sformatf("vec%0d dc_err", i), 32'(bus.dc_err), 32'(vecs[i].e_dc_err));
        end

        // Both requesters held from reset: IC, DC, IC, DC with acks 3 cycles apart
        clear_inputs();
        do_reset();
        bus.ic_req = 1'b1;  bus.ic_addr = 32'h10;
        bus.dc_req = 1'b1;  bus.dc_addr = 32'h20;  bus.dc_rd_wr = 1'b1;
        bus.mem_data_valid = 1'b1;  bus.mem_rdata = 32'h5A;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("tie c%0d ic_ack", c), 32'(bus.ic_ack), 32'((c % 6) == 2));
            check($sformatf("tie c%0d dc_ack", c), 32'(bus.dc_ack), 32'((c % 6) == 5));
            if ((c % 3) == 1) begin
                check($sformatf("tie c%0d mem_addr", c), bus.mem_addr, ((c % 6) == 1) ? 32'h10 : 32'h20);
                check($sformatf("tie c%0d mem_en", c), 32'(bus.mem_en), 32'h1);
            end
        end
        check("tie ic_rdata", bus.ic_rdata, 32'h5A);
        check("tie dc_rdata", bus.dc_rdata, 32'h5A);

        // Reset during an IC access, then a tie must go to IC again
        clear_inputs();
        do_reset();
        bus.ic_req = 1'b1;  bus.ic_addr = 32'h10;
        bus.dc_req = 1'b1;  bus.dc_addr = 32'h20;  bus.dc_rd_wr = 1'b1;
        tick();
        check("rst busy mem_en",   32'(bus.mem_en), 32'h1);
        check("rst busy mem_addr", bus.mem_addr,    32'h10);
        reset = 1'b1;
        tick();
        check("rst mid mem_en", 32'(bus.mem_en), 32'h0);
        check("rst mid ic_ack", 32'(bus.ic_ack), 32'h0);
        check("rst mid dc_ack", 32'(bus.dc_ack), 32'h0);
        reset = 1'b0;
        tick();
        check("post rst mem_en",    32'(bus.mem_en),    32'h1);
        check("post rst mem_addr",  bus.mem_addr,       32'h10);
        check("post rst mem_rd_wr", 32'(bus.mem_rd_wr), 32'h1);
        check("post rst ic_ack",    32'(bus.ic_ack),    32'h0);
        bus.mem_data_valid = 1'b1;  bus.mem_rdata = 32'h66;
        tick();
        check("post rst ic_ack2",  32'(bus.ic_ack), 32'h1);
        check("post rst dc_ack2",  32'(bus.dc_ack), 32'h0);
        check("post rst ic_rdata", bus.ic_rdata,    32'h66);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
